// File: rtl/uart_rx_if.sv
// Receive-side consumer interface of uart_rx_buffered: FWFT byte stream plus
// buffer occupancy and sticky error status.
interface uart_rx_if #(
  parameter int DEPTH = 8
);
  logic [7:0]              data_out;
  logic                    data_out_valid;
  logic                    data_out_ready;
  logic [$clog2(DEPTH):0]  count;
  logic                    framing_error;
  logic                    overflow;
  logic                    clear_errors;

  modport master (
    output data_out, data_out_valid, count, framing_error, overflow,
    input  data_out_ready, clear_errors
  );

  modport slave (
    input  data_out, data_out_valid, count, framing_error, overflow,
    output data_out_ready, clear_errors
  );
endinterface

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with a first-word-fall-through receive FIFO and sticky
// framing/overflow status.
module uart_rx_buffered #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DEPTH      = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     serial_in,
  uart_rx_if.master rx
);
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CYC_W            = $clog2(SYMBOL_EDGE_TIME);
  localparam int PTR_W            = $clog2(DEPTH);
  localparam int CNT_W            = PTR_W + 1;
  localparam logic [CYC_W-1:0] SAMPLE_LAST = CYC_W'(SAMPLE_TIME - 1);
  localparam logic [CYC_W-1:0] SYMBOL_LAST = CYC_W'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t             state, state_next;
  logic               rx_sync_p0, rx_s;
  logic [CYC_W-1:0]   cyc;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift;
  logic               cyc_clr, bit_take, push, set_fe;

  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               framing_error, overflow;
  logic               pop, full, wr_en, ovf_set;

  // Stage p0/p1: two-flop synchroniser, idle-high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_sync_p0 <= serial_in;
      rx_s       <= rx_sync_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cyc     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state <= state_next;
      cyc   <= cyc_clr ? '0 : cyc + 1'b1;
      if (state == S_IDLE)
        bit_cnt <= '0;
      else if (bit_take)
        bit_cnt <= bit_cnt + 1'b1;
      if (bit_take)
        shift <= {rx_s, shift[7:1]};
    end
  end

  // START waits half a symbol so every later sample lands mid-bit
  always_comb begin
    state_next = state;
    cyc_clr    = 1'b0;
    bit_take   = 1'b0;
    push       = 1'b0;
    set_fe     = 1'b0;
    case (state)
      S_IDLE: begin
        cyc_clr = 1'b1;
        if (!rx_s) state_next = S_START;
      end
      S_START: begin
        if (cyc == SAMPLE_LAST) begin
          cyc_clr    = 1'b1;
          state_next = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cyc == SYMBOL_LAST) begin
          cyc_clr  = 1'b1;
          bit_take = 1'b1;
          if (bit_cnt == 3'd7) state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (cyc == SYMBOL_LAST) begin
          cyc_clr = 1'b1;
          if (rx_s) begin
            push       = 1'b1;
            state_next = S_IDLE;
          end else begin
            set_fe     = 1'b1;
            state_next = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        cyc_clr = 1'b1;
        if (rx_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign pop     = (count != '0) && rx.data_out_ready;
  assign full    = (count == CNT_W'(DEPTH));
  // A full FIFO still accepts a byte when the head is leaving this cycle
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky status: a new error wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      framing_error <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (set_fe)                framing_error <= 1'b1;
      else if (rx.clear_errors)  framing_error <= 1'b0;
      if (ovf_set)               overflow <= 1'b1;
      else if (rx.clear_errors)  overflow <= 1'b0;
    end
  end

  assign rx.data_out       = mem[rd_ptr];
  assign rx.data_out_valid = (count != '0);
  assign rx.count          = count;
  assign rx.framing_error  = framing_error;
  assign rx.overflow       = overflow;
endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered at 100 clocks per bit.
module tb_uart_rx_buffered;
  localparam int CLOCK_FREQ = 125_000_000;
  localparam int BAUD_RATE  = 1_250_000;
  localparam int DEPTH      = 8;
  localparam int BIT        = CLOCK_FREQ / BAUD_RATE;

  logic clk = 1'b0;
  logic rst;
  logic serial_in;

  uart_rx_if #(.DEPTH(DEPTH)) rx_if ();

  uart_rx_buffered #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .serial_in(serial_in),
    .rx       (rx_if)
  );

  always #4 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_pops  = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected byte is queued when the frame is driven, unless the model FIFO is full
  task automatic send(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovf = 1'b1;
    end
    serial_in = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      tick(BIT);
    end
    serial_in = stop;
    tick(BIT);
    serial_in = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [31:0] want;
    if (!rst && rx_if.data_out_valid && rx_if.data_out_ready) begin
      n_pops++;
      want = (exp_q.size() != 0) ? {24'h0, exp_q.pop_front()} : 32'hDEAD_BEEF;
      chk_val("pop_data", {24'h0, rx_if.data_out}, want);
    end
  end

  initial begin
    #(8 * 80000);
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    serial_in = 1'b1;
    rx_if.data_out_ready = 1'b0;
    rx_if.clear_errors = 1'b0;
    exp_ovf = 1'b0;
    tick(3);
    chk_val("rst_count", 32'(rx_if.count), 0);
    chk_val("rst_valid", 32'(rx_if.data_out_valid), 0);
    chk_val("rst_data", 32'(rx_if.data_out), 0);
    chk_val("rst_fe", 32'(rx_if.framing_error), 0);
    chk_val("rst_ovf", 32'(rx_if.overflow), 0);
    rst = 1'b0;
    tick(5);

    send(8'hAC, 1'b1);
    tick(5);
    chk_val("t1_count", 32'(rx_if.count), 1);
    chk_val("t1_valid", 32'(rx_if.data_out_valid), 1);
    chk_val("t1_head", 32'(rx_if.data_out), 32'hAC);
    chk_val("t1_fe", 32'(rx_if.framing_error), 0);
    chk_val("t1_ovf", 32'(rx_if.overflow), 0);

    send(8'hAF, 1'b1);
    tick(5);
    chk_val("t2_count", 32'(rx_if.count), 2);
    rx_if.data_out_ready = 1'b1;
    tick(5);
    chk_val("t2_count_drained", 32'(rx_if.count), 0);
    chk_val("t2_valid", 32'(rx_if.data_out_valid), 0);
    chk_val("t2_pops", n_pops, 2);
    rx_if.data_out_ready = 1'b0;

    for (int i = 0; i < 9; i++) send(8'(i), 1'b1);
    tick(5);
    chk_val("t3_count_full", 32'(rx_if.count), DEPTH);
    chk_val("t3_ovf", 32'(rx_if.overflow), 32'(exp_ovf));
    rx_if.data_out_ready = 1'b1;
    tick(12);
    rx_if.data_out_ready = 1'b0;
    chk_val("t3_count_drained", 32'(rx_if.count), 0);
    rx_if.clear_errors = 1'b1;
    tick(1);
    rx_if.clear_errors = 1'b0;
    exp_ovf = 1'b0;
    chk_val("t3_ovf_cleared", 32'(rx_if.overflow), 0);

    send(8'h55, 1'b0);
    serial_in = 1'b0;
    tick(3 * BIT);
    serial_in = 1'b1;
    tick(BIT);
    send(8'h3C, 1'b1);
    tick(5);
    chk_val("t4_fe", 32'(rx_if.framing_error), 1);
    chk_val("t4_count", 32'(rx_if.count), 1);
    chk_val("t4_head", 32'(rx_if.data_out), 32'h3C);
    rx_if.clear_errors = 1'b1;
    tick(1);
    rx_if.clear_errors = 1'b0;
    chk_val("t4_fe_cleared", 32'(rx_if.framing_error), 0);
    rx_if.data_out_ready = 1'b1;
    tick(3);
    rx_if.data_out_ready = 1'b0;

    serial_in = 1'b0;
    tick(20);
    serial_in = 1'b1;
    tick(2 * BIT);
    chk_val("t5_count", 32'(rx_if.count), 0);
    chk_val("t5_valid", 32'(rx_if.data_out_valid), 0);
    chk_val("t5_fe", 32'(rx_if.framing_error), 0);
    chk_val("t5_ovf", 32'(rx_if.overflow), 0);

    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    tick(5);
    chk_val("t6_count_pre", 32'(rx_if.count), 3);
    serial_in = 1'b0;
    tick(BIT);
    for (int i = 0; i < 4; i++) begin
      serial_in = 1'(8'hA5 >> i);
      tick(BIT);
    end
    serial_in = 1'(8'hA5 >> 4);
    tick(BIT / 2);
    rst = 1'b1;
    exp_q.delete();
    serial_in = 1'b1;
    tick(3);
    chk_val("t6_rst_count", 32'(rx_if.count), 0);
    chk_val("t6_rst_valid", 32'(rx_if.data_out_valid), 0);
    chk_val("t6_rst_data", 32'(rx_if.data_out), 0);
    chk_val("t6_rst_fe", 32'(rx_if.framing_error), 0);
    chk_val("t6_rst_ovf", 32'(rx_if.overflow), 0);
    rst = 1'b0;
    tick(5);
    send(8'hA5, 1'b1);
    tick(5);
    chk_val("t6_count", 32'(rx_if.count), 1);
    chk_val("t6_head", 32'(rx_if.data_out), 32'hA5);
    rx_if.data_out_ready = 1'b1;
    tick(3);
    rx_if.data_out_ready = 1'b0;
    chk_val("t6_count_drained", 32'(rx_if.count), 0);

    chk_val("total_pops", n_pops, 12);
    chk_val("sb_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
